ft_fault_sequencer: RTL and testbench
=====================================

Name: ft_fault_sequencer

Overview:
- Programmable, multi-channel fault-injection sequencer with a completion watchdog for the fault-tolerant core SoC.
- Each channel drives one error strobe into a core or replica. The strobe fires as a configurable train of pulses: start delay, pulse length, gap and repeat count.
- The watchdog counts cycles from launch. It flags completion when the program's done flag rises and flags timeout otherwise.
- Replaces hand-timed error pulses and fixed-delay timeouts in SoC benches. Also usable as an on-chip fault-campaign engine.

Parameters:
- N_CH, 2, number of independent error channels (1..16).
- CNT_W, 16, width of the delay, length and gap counters.
- REP_W, 4, width of the repeat count per channel.
- TIMEOUT, 2000, watchdog limit in cycles after launch.
- CH_W, $clog2(N_CH) min 1, derived; width of the channel select.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cfg_we_i  in  1  write channel configuration; accepted only in IDLE.
- cfg_ch_i  in  CH_W  channel index for the write; writes with index >= N_CH are ignored.
- cfg_delay_i  in  CNT_W  cycles from launch to the first pulse.
- cfg_len_i  in  CNT_W  pulse high time in cycles; 0 is treated as 1.
- cfg_gap_i  in  CNT_W  low time between pulses in cycles; 0 is treated as 1.
- cfg_reps_i  in  REP_W  number of pulses; 0 disables the channel.
- start_i  in  1  launch the campaign; ignored while busy_o=1.
- abort_i  in  1  stop all channels immediately.
- done_flag_i  in  1  program-completion flag (the SoC mem flag).
- error_o  out  N_CH  error strobes, one bit per channel.
- busy_o  out  1  high while any channel is active.
- finished_o  out  1  sticky: done_flag_i was seen after launch, before timeout.
- timeout_o  out  1  sticky: TIMEOUT elapsed without done_flag_i.
- pulse_cnt_o  out  N_CH*REP_W  pulses emitted so far per channel; channel c occupies bits [c*REP_W +: REP_W].

Behaviour:
- Reset values: all outputs 0; every configuration register 0; all channel FSMs in IDLE; watchdog stopped.
- Config: cfg_we_i is sampled at the edge. It is accepted only when busy_o=0 and the watchdog is not running, and is silently dropped otherwise.
- Config written on the same edge as start_i is stored, but the launch uses the values held before that edge.
- Launch: start_i high at edge k, with busy_o=0 → on the same edge:
  - clear finished_o, timeout_o and all pulse_cnt fields;
  - start the watchdog at 0;
  - each channel with reps>0 enters DELAY; channels with reps=0 enter DONE.
- Channel FSM states: IDLE, DELAY, PULSE, GAP, DONE.
  - DELAY: holds for delay cycles, then goes to PULSE. With delay=0, PULSE starts the cycle after k.
  - Timing: error_o[c] is high during cycles k+1+delay .. k+delay+len', where len' = max(len,1).
  - PULSE: error_o[c]=1 for len' cycles. pulse_cnt increments on the PULSE entry edge, saturating at 2^REP_W-1.
  - End of PULSE: if the emitted count equals reps, go to DONE; otherwise go to GAP.
  - GAP: error_o[c]=0 for gap' = max(gap,1) cycles, then back to PULSE.
  - DONE: stays until the next launch. A DONE channel is ready for relaunch.
- error_o is registered and depends on FSM state only; there is no combinational path from inputs.
- busy_o: high from cycle k+1 while any channel is in DELAY, PULSE or GAP. It drops the cycle after the last channel reaches DONE.
  - If every channel has reps=0, busy_o stays 0.
- Watchdog: increments every cycle after launch.
  - First edge with done_flag_i=1 → finished_o=1 and the watchdog stops.
  - Count reaching TIMEOUT without done_flag_i → timeout_o=1 and the watchdog stops.
  - If done_flag_i=1 on the same edge the count reaches TIMEOUT, finished_o wins.
  - done_flag_i outside a running watchdog is ignored.
  - The watchdog runs independently of busy_o; pulses may still be running after finished_o.
- Abort: abort_i high → on that edge all channels go to IDLE, error_o clears to 0 on the next cycle, busy_o goes to 0 and the watchdog stops.
  - finished_o, timeout_o and pulse_cnt_o keep their values.
  - abort_i beats start_i when both are high on the same edge.
- Reset mid-campaign: everything returns to reset values, including the configuration.
- Counters are unsigned CNT_W-bit values. The maximum delay of 2^CNT_W-1 must be honoured with no wrap.

Test Plan:
- N_CH=2. Ch0 delay=172, len=2, gap=58, reps=2; launch at k=10 → error_o[0] high at cycles 183–184 and 243–244; pulse_cnt0=2; busy_o falls at cycle 245.
- Ch1 reps=0, ch0 delay=0, len=0, reps=1 → error_o[0] high exactly at cycle k+1; busy_o high for 1 cycle; error_o[1] stays 0.
- TIMEOUT=50, done_flag_i never rises → timeout_o=1 at launch+50 cycles; finished_o=0. Relaunch clears timeout_o.
- done_flag_i pulses at launch+30 → finished_o=1 and sticky; a later done_flag_i or the TIMEOUT boundary leaves timeout_o=0. Also check done_flag_i arriving exactly at count TIMEOUT → finished_o=1, timeout_o=0.
- Ch0 len=100; assert abort_i mid-pulse → error_o=0 next cycle; busy_o=0; pulse_cnt0=1 held. A cfg_we_i issued while busy is dropped (read back via the next campaign's timing).
- start_i together with cfg_we_i (delay 5→20) → this campaign uses delay=5; the next campaign uses delay=20. start_i while busy_o=1 → no effect on counters or timing.

Source files
------------

// File: rtl/ft_fault_sequencer.sv
// rtl/ft_fault_sequencer.sv - multi-channel fault pulse-train sequencer with completion watchdog
module ft_fault_sequencer #(
    parameter int N_CH    = 2,
    parameter int CNT_W   = 16,
    parameter int REP_W   = 4,
    parameter int TIMEOUT = 2000,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_we_i,
    input  logic [CH_W-1:0]         cfg_ch_i,
    input  logic [CNT_W-1:0]        cfg_delay_i,
    input  logic [CNT_W-1:0]        cfg_len_i,
    input  logic [CNT_W-1:0]        cfg_gap_i,
    input  logic [REP_W-1:0]        cfg_reps_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    done_flag_i,
    output logic [N_CH-1:0]         error_o,
    output logic                    busy_o,
    output logic                    finished_o,
    output logic                    timeout_o,
    output logic [N_CH*REP_W-1:0]   pulse_cnt_o
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [CH_W:0] N_CH_V = (CH_W + 1)'(N_CH);

    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_PULSE, S_GAP, S_DONE} state_t;

    state_t           state     [N_CH];
    logic [CNT_W-1:0] cnt       [N_CH];
    logic [CNT_W-1:0] cfg_delay [N_CH];
    logic [CNT_W-1:0] cfg_len   [N_CH];
    logic [CNT_W-1:0] cfg_gap   [N_CH];
    logic [REP_W-1:0] cfg_reps  [N_CH];
    logic [CNT_W-1:0] run_len   [N_CH];
    logic [CNT_W-1:0] run_gap   [N_CH];
    logic [REP_W-1:0] run_reps  [N_CH];
    logic [WD_W-1:0]  wd_cnt;
    logic             wd_run;
    logic             any_active;
    logic             keep_busy;
    logic             launch;
    logic             cfg_ok;

    // Counters hold "cycles remaining minus one"; a programmed 0 behaves as 1.
    function automatic logic [CNT_W-1:0] minus1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // keep_busy: some channel is still running after this edge (launch edge excluded).
    always_comb begin
        any_active = 1'b0;
        keep_busy  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            case (state[c])
                S_DELAY, S_GAP: begin
                    any_active = 1'b1;
                    keep_busy  = 1'b1;
                end
                S_PULSE: begin
                    any_active = 1'b1;
                    if (cnt[c] != '0 || pulse_cnt_o[c*REP_W +: REP_W] != run_reps[c])
                        keep_busy = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign launch = start_i && !abort_i && !any_active;
    assign cfg_ok = cfg_we_i && !busy_o && !wd_run && ({1'b0, cfg_ch_i} < N_CH_V);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                cfg_delay[c] <= '0;
                cfg_len[c]   <= '0;
                cfg_gap[c]   <= '0;
                cfg_reps[c]  <= '0;
            end
        end else if (cfg_ok) begin
            cfg_delay[cfg_ch_i] <= cfg_delay_i;
            cfg_len[cfg_ch_i]   <= cfg_len_i;
            cfg_gap[cfg_ch_i]   <= cfg_gap_i;
            cfg_reps[cfg_ch_i]  <= cfg_reps_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                state[c]    <= S_IDLE;
                cnt[c]      <= '0;
                run_len[c]  <= '0;
                run_gap[c]  <= '0;
                run_reps[c] <= '0;
            end
            error_o     <= '0;
            busy_o      <= 1'b0;
            pulse_cnt_o <= '0;
        end else if (abort_i) begin
            for (int c = 0; c < N_CH; c++)
                state[c] <= S_IDLE;
            error_o <= '0;
            busy_o  <= 1'b0;
        end else if (launch) begin
            // Launch snapshots the configuration so a same-edge write only affects later campaigns.
            for (int c = 0; c < N_CH; c++) begin
                state[c]    <= (cfg_reps[c] != '0) ? S_DELAY : S_DONE;
                cnt[c]      <= cfg_delay[c];
                run_len[c]  <= cfg_len[c];
                run_gap[c]  <= cfg_gap[c];
                run_reps[c] <= cfg_reps[c];
            end
            error_o     <= '0;
            busy_o      <= 1'b0;
            pulse_cnt_o <= '0;
        end else begin
            busy_o <= keep_busy;
            for (int c = 0; c < N_CH; c++) begin
                case (state[c])
                    S_DELAY, S_GAP: begin
                        if (cnt[c] == '0) begin
                            state[c]   <= S_PULSE;
                            cnt[c]     <= minus1(run_len[c]);
                            error_o[c] <= 1'b1;
                            if (pulse_cnt_o[c*REP_W +: REP_W] != '1)
                                pulse_cnt_o[c*REP_W +: REP_W] <= pulse_cnt_o[c*REP_W +: REP_W] + 1'b1;
                        end else begin
                            cnt[c] <= cnt[c] - 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (cnt[c] == '0) begin
                            error_o[c] <= 1'b0;
                            if (pulse_cnt_o[c*REP_W +: REP_W] == run_reps[c]) begin
                                state[c] <= S_DONE;
                            end else begin
                                state[c] <= S_GAP;
                                cnt[c]   <= minus1(run_gap[c]);
                            end
                        end else begin
                            cnt[c] <= cnt[c] - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Completion wins over timeout when both land on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_run     <= 1'b0;
            wd_cnt     <= '0;
            finished_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else if (abort_i) begin
            wd_run <= 1'b0;
        end else if (launch) begin
            wd_run     <= 1'b1;
            wd_cnt     <= '0;
            finished_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else if (wd_run) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (done_flag_i) begin
                finished_o <= 1'b1;
                wd_run     <= 1'b0;
            end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                timeout_o <= 1'b1;
                wd_run    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ft_fault_sequencer.sv
// tb/tb_ft_fault_sequencer.sv - self-checking bench for ft_fault_sequencer
module tb_ft_fault_sequencer;
    localparam int TO   = 50;
    localparam int NONE = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_we_i = 1'b0;
    logic [0:0]  cfg_ch_i = '0;
    logic [15:0] cfg_delay_i = '0;
    logic [15:0] cfg_len_i = '0;
    logic [15:0] cfg_gap_i = '0;
    logic [3:0]  cfg_reps_i = '0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        done_flag_i = 1'b0;
    logic [1:0]  error_o;
    logic        busy_o;
    logic        finished_o;
    logic        timeout_o;
    logic [7:0]  pulse_cnt_o;

    ft_fault_sequencer #(.N_CH(2), .CNT_W(16), .REP_W(4), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i),
        .cfg_delay_i(cfg_delay_i), .cfg_len_i(cfg_len_i), .cfg_gap_i(cfg_gap_i),
        .cfg_reps_i(cfg_reps_i), .start_i(start_i), .abort_i(abort_i),
        .done_flag_i(done_flag_i), .error_o(error_o), .busy_o(busy_o),
        .finished_o(finished_o), .timeout_o(timeout_o), .pulse_cnt_o(pulse_cnt_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit checking = 1'b0;

    // Model: campaign described by launch edge, snapshot config, abort edge and first done edge.
    int m_d[2], m_l[2], m_g[2], m_r[2];
    int r_d[2], r_l[2], r_g[2], r_r[2];
    int k_l = -1;
    int a_e = NONE;
    int f_e = -1;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int run_end();
        int e = -1;
        for (int c = 0; c < 2; c++)
            if (r_r[c] > 0) begin
                int x;
                x = k_l + r_d[c] + r_r[c] * eff(r_l[c]) + (r_r[c] - 1) * eff(r_g[c]);
                if (x > e) e = x;
            end
        return e;
    endfunction

    function automatic bit busy_at(input int t);
        if (k_l < 0 || t >= a_e) return 1'b0;
        return (t >= k_l + 1) && (t <= run_end());
    endfunction

    function automatic bit err_at(input int c, input int t);
        int s;
        int p;
        if (k_l < 0 || t >= a_e || r_r[c] == 0) return 1'b0;
        s = t - (k_l + 1 + r_d[c]);
        if (s < 0) return 1'b0;
        p = eff(r_l[c]) + eff(r_g[c]);
        return (s / p < r_r[c]) && (s % p < eff(r_l[c]));
    endfunction

    function automatic int pcnt_at(input int c, input int t);
        int te;
        int s;
        int n;
        if (k_l < 0 || r_r[c] == 0) return 0;
        te = (a_e - 1 < t) ? a_e - 1 : t;
        s = k_l + 1 + r_d[c];
        if (te < s) return 0;
        n = (te - s) / (eff(r_l[c]) + eff(r_g[c])) + 1;
        return (n > r_r[c]) ? r_r[c] : n;
    endfunction

    function automatic bit wd_run_at(input int t);
        return k_l >= 0 && t >= k_l && t < k_l + TO && t < a_e && (f_e < 0 || t < f_e);
    endfunction

    function automatic bit fin_at(input int t);
        return f_e >= 0 && t >= f_e;
    endfunction

    function automatic bit to_at(input int t);
        return k_l >= 0 && f_e < 0 && t >= k_l + TO && a_e > k_l + TO;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_i) begin
            k_l <= -1;
            a_e <= NONE;
            f_e <= -1;
            for (int c = 0; c < 2; c++) begin
                m_d[c] <= 0; m_l[c] <= 0; m_g[c] <= 0; m_r[c] <= 0;
            end
        end else begin
            if (cfg_we_i && !busy_at(cyc) && !wd_run_at(cyc)) begin
                m_d[cfg_ch_i] <= int'(cfg_delay_i);
                m_l[cfg_ch_i] <= int'(cfg_len_i);
                m_g[cfg_ch_i] <= int'(cfg_gap_i);
                m_r[cfg_ch_i] <= int'(cfg_reps_i);
            end
            if (abort_i) begin
                a_e <= cyc + 1;
            end else if (start_i && !busy_at(cyc)) begin
                k_l <= cyc + 1;
                a_e <= NONE;
                f_e <= -1;
                for (int c = 0; c < 2; c++) begin
                    r_d[c] <= m_d[c]; r_l[c] <= m_l[c]; r_g[c] <= m_g[c]; r_r[c] <= m_r[c];
                end
            end else if (done_flag_i && wd_run_at(cyc) && f_e < 0) begin
                f_e <= cyc + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking && cyc >= 1) begin
            check("model error0", 32'(error_o[0]), 32'(err_at(0, cyc)));
            check("model error1", 32'(error_o[1]), 32'(err_at(1, cyc)));
            check("model busy", 32'(busy_o), 32'(busy_at(cyc)));
            check("model finished", 32'(finished_o), 32'(fin_at(cyc)));
            check("model timeout", 32'(timeout_o), 32'(to_at(cyc)));
            check("model pcnt0", 32'(pulse_cnt_o[3:0]), 32'(pcnt_at(0, cyc)));
            check("model pcnt1", 32'(pulse_cnt_o[7:4]), 32'(pcnt_at(1, cyc)));
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic cfg(input int e, input int ch, input int d, input int l, input int g, input int r);
        wait_cyc(e - 1);
        cfg_we_i = 1'b1; cfg_ch_i = 1'(ch);
        cfg_delay_i = 16'(d); cfg_len_i = 16'(l); cfg_gap_i = 16'(g); cfg_reps_i = 4'(r);
        wait_cyc(e);
        cfg_we_i = 1'b0;
    endtask

    task automatic fire_start(input int e);
        wait_cyc(e - 1); start_i = 1'b1; wait_cyc(e); start_i = 1'b0;
    endtask

    task automatic fire_done(input int e);
        wait_cyc(e - 1); done_flag_i = 1'b1; wait_cyc(e); done_flag_i = 1'b0;
    endtask

    task automatic fire_abort(input int e);
        wait_cyc(e - 1); abort_i = 1'b1; wait_cyc(e); abort_i = 1'b0;
    endtask

    initial begin
        checking = 1'b1;
        wait_cyc(3); rst_i = 1'b0;
        wait_cyc(4);
        check("reset error", 32'(error_o), 0);
        check("reset busy", 32'(busy_o), 0);
        check("reset finished", 32'(finished_o), 0);
        check("reset timeout", 32'(timeout_o), 0);
        check("reset pcnt", 32'(pulse_cnt_o), 0);

        // Two-pulse train on ch0, ch1 disabled, no done flag.
        cfg(5, 0, 172, 2, 58, 2);
        fire_start(10);
        check("busy at launch", 32'(busy_o), 0);
        wait_cyc(11);  check("busy k+1", 32'(busy_o), 1);
        wait_cyc(59);  check("timeout early", 32'(timeout_o), 0);
        wait_cyc(60);  check("timeout hit", 32'(timeout_o), 1);
        check("no finish", 32'(finished_o), 0);
        wait_cyc(182); check("ch0 pre", 32'(error_o[0]), 0);
        wait_cyc(183); check("ch0 rise1", 32'(error_o[0]), 1);
        wait_cyc(184); check("ch0 hold1", 32'(error_o[0]), 1);
        wait_cyc(185); check("ch0 gap", 32'(error_o[0]), 0);
        wait_cyc(243); check("ch0 rise2", 32'(error_o[0]), 1);
        wait_cyc(244); check("busy last", 32'(busy_o), 1);
        wait_cyc(245);
        check("ch0 end", 32'(error_o[0]), 0);
        check("busy fall", 32'(busy_o), 0);
        check("pcnt0 two", 32'(pulse_cnt_o[3:0]), 2);
        check("ch1 idle", 32'(error_o[1]), 0);

        // Single zero-length pulse, done flag at launch+30.
        cfg(247, 0, 0, 0, 0, 1);
        fire_start(250);
        check("relaunch clears timeout", 32'(timeout_o), 0);
        wait_cyc(251);
        check("short pulse", 32'(error_o[0]), 1);
        check("short busy", 32'(busy_o), 1);
        check("short pcnt", 32'(pulse_cnt_o[3:0]), 1);
        wait_cyc(252);
        check("short end", 32'(error_o[0]), 0);
        check("short busy end", 32'(busy_o), 0);
        wait_cyc(279); check("finish early", 32'(finished_o), 0);
        fire_done(280);
        check("finish", 32'(finished_o), 1);
        fire_done(290);
        wait_cyc(305);
        check("finish sticky", 32'(finished_o), 1);
        check("no timeout after finish", 32'(timeout_o), 0);

        // Done flag exactly at the timeout boundary, all channels disabled.
        cfg(306, 0, 0, 0, 0, 0);
        fire_start(310);
        wait_cyc(311);
        check("idle campaign busy", 32'(busy_o), 0);
        check("finish cleared", 32'(finished_o), 0);
        fire_done(360);
        check("boundary finish", 32'(finished_o), 1);
        check("boundary timeout", 32'(timeout_o), 0);

        // Long pulse aborted; config write while busy is dropped.
        cfg(362, 0, 3, 100, 1, 3);
        fire_start(365);
        cfg(380, 0, 7, 100, 1, 3);
        wait_cyc(399); check("long pulse", 32'(error_o[0]), 1);
        fire_abort(400);
        check("abort error", 32'(error_o[0]), 0);
        check("abort busy", 32'(busy_o), 0);
        check("abort pcnt", 32'(pulse_cnt_o[3:0]), 1);
        wait_cyc(420);
        check("abort wd stop", 32'(timeout_o), 0);
        check("abort pcnt held", 32'(pulse_cnt_o[3:0]), 1);
        fire_start(425);
        check("relaunch pcnt", 32'(pulse_cnt_o[3:0]), 0);
        wait_cyc(428); check("dropped cfg pre", 32'(error_o[0]), 0);
        wait_cyc(429); check("dropped cfg rise", 32'(error_o[0]), 1);
        fire_abort(435);

        // Config on the launch edge applies to the next campaign; start while busy ignored.
        cfg(437, 0, 5, 1, 1, 1);
        wait_cyc(439);
        start_i = 1'b1; cfg_we_i = 1'b1; cfg_ch_i = 1'b0;
        cfg_delay_i = 16'd20; cfg_len_i = 16'd1; cfg_gap_i = 16'd1; cfg_reps_i = 4'd1;
        wait_cyc(440);
        start_i = 1'b0; cfg_we_i = 1'b0;
        fire_start(443);
        wait_cyc(445); check("old delay pre", 32'(error_o[0]), 0);
        wait_cyc(446); check("old delay rise", 32'(error_o[0]), 1);
        wait_cyc(447);
        check("old delay end", 32'(error_o[0]), 0);
        check("old delay busy", 32'(busy_o), 0);
        check("busy start ignored pcnt", 32'(pulse_cnt_o[3:0]), 1);
        fire_start(450);
        wait_cyc(470); check("new delay pre", 32'(error_o[0]), 0);
        wait_cyc(471); check("new delay rise", 32'(error_o[0]), 1);

        // Reset mid-watchdog clears everything including configuration.
        wait_cyc(474); rst_i = 1'b1;
        wait_cyc(476); rst_i = 1'b0;
        wait_cyc(477);
        check("rst busy", 32'(busy_o), 0);
        check("rst pcnt", 32'(pulse_cnt_o), 0);
        check("rst finished", 32'(finished_o), 0);
        fire_start(480);
        wait_cyc(481);
        check("rst cfg busy", 32'(busy_o), 0);
        check("rst cfg error", 32'(error_o), 0);
        wait_cyc(529); check("rst wd early", 32'(timeout_o), 0);
        wait_cyc(530); check("rst wd timeout", 32'(timeout_o), 1);
        wait_cyc(535);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
